// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction field positions, NOP opcode,
// fetch FSM encoding and the field decode helper used to build the registered outputs.
package instr_fetch_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    localparam logic [5:0] NOP_OPCODE = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    // An invalid head decodes to NOP with every other field cleared.
    function automatic instr_fields_t decode_fields(input logic [DATA_WIDTH-1:0] word,
                                                    input logic valid);
        instr_fields_t f;
        f = {$bits(instr_fields_t){1'b0}};
        if (valid) begin
            f.opcode = word[OPCODE_LSB +: 6];
            f.rs     = word[RS_LSB +: 5];
            f.rt     = word[RT_LSB +: 5];
            f.rd     = word[RD_LSB +: 5];
            f.shamt  = word[SHAMT_LSB +: 5];
            f.funct  = word[FUNCT_LSB +: 6];
            f.imm    = word[IMM_LSB +: 16];
        end else begin
            f.opcode = NOP_OPCODE;
        end
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_prefetch_queue.sv
// Circular prefetch FIFO. Besides full/empty/count it exposes the head as it will be
// after this cycle's push/pop/flush, so the fetch unit can register its outputs from it.
module ifu_prefetch_queue #(
    parameter int ENTRY_W = 58,
    parameter int DEPTH   = 2,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count,
    output logic               head_nxt_valid,
    output logic [ENTRY_W-1:0] head_nxt_data
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               push_s;
    logic               pop_s;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Pointer update and look-ahead head selection.
    always_comb begin
        push_s   = push && !flush && !full;
        pop_s    = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {(PTR_W+1){1'b0}};
            rd_ptr_d = {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        end
        head_nxt_valid = (wr_ptr_d != rd_ptr_d);
        // A word pushed into a queue that is otherwise empty becomes the head directly.
        if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_nxt_data = push_data;
        end else begin
            head_nxt_data = mem_q[rd_ptr_d[PTR_W-1:0]];
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: requests words from instruction memory, buffers them in the prefetch
// queue and presents registered R-format fields of the head (NOP when nothing is ready).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 26,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter int                    PF_DEPTH   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_READ,
    input  logic [31:0]           MEM_DATA,
    input  logic                  MEM_READY,
    input  logic                  NEXT,
    input  logic                  PC_LOAD,
    input  logic [ADDR_WIDTH-1:0] PC_IN,
    output logic                  INSTR_VALID,
    output logic [5:0]            OpCode,
    output logic [4:0]            ADDR_R1,
    output logic [4:0]            ADDR_R2,
    output logic [4:0]            ADDR_W,
    output logic [4:0]            Shamt,
    output logic [5:0]            Funct,
    output logic [15:0]           IMM,
    output logic [ADDR_WIDTH-1:0] PC_OUT
);

    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int CNT_W   = $clog2(PF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]      ROOM_LIMIT = CNT_W'(PF_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  instr_valid_q, instr_valid_d;
    instr_fields_t         fields_q, fields_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;

    logic                  push_s, pop_s, flush_s;
    logic                  q_full_s, q_empty_s, head_valid_s;
    logic [CNT_W-1:0]      q_count_s;
    logic [ENTRY_W-1:0]    head_data_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;

    ifu_prefetch_queue #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (PF_DEPTH)
    ) u_queue (
        .clk            (CLK),
        .rst_n          (RST),
        .push           (push_s),
        .pop            (pop_s),
        .flush          (flush_s),
        .push_data      ({mem_addr_q, MEM_DATA}),
        .full           (q_full_s),
        .empty          (q_empty_s),
        .count          (q_count_s),
        .head_nxt_valid (head_valid_s),
        .head_nxt_data  (head_data_s)
    );

    assign pc_inc_s = pc_q + PC_ONE;

    // Fetch FSM: request sequencing, redirect handling and PC update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_read_d = mem_read_q;
        push_s     = 1'b0;
        flush_s    = PC_LOAD;
        pop_s      = NEXT && instr_valid_q && !q_empty_s && !PC_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (PC_LOAD) begin
                    pc_d       = PC_IN;
                    state_d    = ST_REQ;
                    mem_read_d = 1'b1;
                    mem_addr_d = PC_IN;
                end else if (!q_full_s) begin
                    state_d    = ST_REQ;
                    mem_read_d = 1'b1;
                    mem_addr_d = pc_q;
                end else begin
                    state_d    = ST_IDLE;
                    mem_read_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (PC_LOAD) begin
                    pc_d = PC_IN;
                    // A response landing with the redirect is dropped and we refetch at once.
                    if (MEM_READY) begin
                        state_d    = ST_REQ;
                        mem_read_d = 1'b1;
                        mem_addr_d = PC_IN;
                    end else begin
                        state_d    = ST_DRAIN;
                        mem_read_d = 1'b0;
                    end
                end else if (MEM_READY) begin
                    push_s     = 1'b1;
                    pc_d       = pc_inc_s;
                    mem_addr_d = pc_inc_s;
                    if (pop_s || (q_count_s < ROOM_LIMIT)) begin
                        state_d    = ST_REQ;
                        mem_read_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        mem_read_d = 1'b0;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (PC_LOAD) begin
                    pc_d = PC_IN;
                end else begin
                    pc_d = pc_q;
                end
                if (MEM_READY) begin
                    state_d    = ST_REQ;
                    mem_read_d = 1'b1;
                    mem_addr_d = PC_LOAD ? PC_IN : pc_q;
                end else begin
                    state_d    = ST_DRAIN;
                    mem_read_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Output fields follow the queue head as it stands after this cycle.
    always_comb begin
        instr_valid_d = head_valid_s;
        fields_d      = decode_fields(head_data_s[DATA_WIDTH-1:0], head_valid_s);
        if (head_valid_s) begin
            pc_out_d = head_data_s[ENTRY_W-1:DATA_WIDTH];
        end else begin
            pc_out_d = pc_d;
        end
    end

    // FSM, PC and memory interface registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
        end
    end

    // Registered decoded outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instr_valid_q <= 1'b0;
            fields_q      <= decode_fields({DATA_WIDTH{1'b0}}, 1'b0);
            pc_out_q      <= RESET_PC;
        end else begin
            instr_valid_q <= instr_valid_d;
            fields_q      <= fields_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign MEM_ADDR    = mem_addr_q;
    assign MEM_READ    = mem_read_q;
    assign INSTR_VALID = instr_valid_q;
    assign OpCode      = fields_q.opcode;
    assign ADDR_R1     = fields_q.rs;
    assign ADDR_R2     = fields_q.rt;
    assign ADDR_W      = fields_q.rd;
    assign Shamt       = fields_q.shamt;
    assign Funct       = fields_q.funct;
    assign IMM         = fields_q.imm;
    assign PC_OUT      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue holds the words accepted
// from memory and is compared against the presented head instruction.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [25:0] MEM_ADDR;
    logic        MEM_READ;
    logic [31:0] MEM_DATA;
    logic        MEM_READY;
    logic        NEXT;
    logic        PC_LOAD;
    logic [25:0] PC_IN;
    logic        INSTR_VALID;
    logic [5:0]  OpCode;
    logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W, Shamt;
    logic [5:0]  Funct;
    logic [15:0] IMM;
    logic [25:0] PC_OUT;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] word;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    instr_fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_READ    (MEM_READ),
        .MEM_DATA    (MEM_DATA),
        .MEM_READY   (MEM_READY),
        .NEXT        (NEXT),
        .PC_LOAD     (PC_LOAD),
        .PC_IN       (PC_IN),
        .INSTR_VALID (INSTR_VALID),
        .OpCode      (OpCode),
        .ADDR_R1     (ADDR_R1),
        .ADDR_R2     (ADDR_R2),
        .ADDR_W      (ADDR_W),
        .Shamt       (Shamt),
        .Funct       (Funct),
        .IMM         (IMM),
        .PC_OUT      (PC_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic mem_push(input logic [25:0] a, input logic [31:0] w);
        sb_t e;
        e.addr = a;
        e.word = w;
        sb.push_back(e);
        MEM_DATA  = w;
        MEM_READY = 1'b1;
    endtask

    task automatic check_nop(input string tag);
        chk({tag, ".valid"}, 32'(INSTR_VALID), 32'd0);
        chk({tag, ".opcode"}, 32'(OpCode), 32'd63);
        chk({tag, ".fields"}, {12'(ADDR_R1), 5'(ADDR_R2), 5'(ADDR_W), 5'(Shamt), 5'(Funct)}, 32'd0);
        chk({tag, ".imm"}, 32'(IMM), 32'd0);
    endtask

    task automatic check_head(input string tag);
        sb_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb[0];
            chk({tag, ".valid"}, 32'(INSTR_VALID), 32'd1);
            chk({tag, ".opcode"}, 32'(OpCode), 32'(e.word[31:26]));
            chk({tag, ".r1"}, 32'(ADDR_R1), 32'(e.word[25:21]));
            chk({tag, ".r2"}, 32'(ADDR_R2), 32'(e.word[20:16]));
            chk({tag, ".w"}, 32'(ADDR_W), 32'(e.word[15:11]));
            chk({tag, ".shamt"}, 32'(Shamt), 32'(e.word[10:6]));
            chk({tag, ".funct"}, 32'(Funct), 32'(e.word[5:0]));
            chk({tag, ".imm"}, 32'(IMM), 32'(e.word[15:0]));
            chk({tag, ".pc"}, 32'(PC_OUT), 32'(e.addr));
        end
    endtask

    task automatic check_mem(input string tag, input logic rd, input logic [25:0] a);
        chk({tag, ".mem_read"}, 32'(MEM_READ), 32'(rd));
        if (rd) begin
            chk({tag, ".mem_addr"}, 32'(MEM_ADDR), 32'(a));
        end
    endtask

    task automatic check_reset(input string tag);
        check_nop(tag);
        chk({tag, ".mem_read"}, 32'(MEM_READ), 32'd0);
        chk({tag, ".mem_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, ".pc_out"}, 32'(PC_OUT), 32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        MEM_DATA  = 32'h0;
        MEM_READY = 1'b0;
        NEXT      = 1'b0;
        PC_LOAD   = 1'b0;
        PC_IN     = 26'h0;
        #1 RST = 1'b0;
        #1 check_reset("rst");

        // Reset release with memory idle: request at 0, nothing becomes valid.
        tick();
        RST = 1'b1;
        tick();
        check_mem("t1_req", 1'b1, 26'h0);
        check_nop("t1_nop");
        repeat (3) tick();
        check_mem("t1_hold", 1'b1, 26'h0);
        check_nop("t1_idle");

        // Zero-wait streaming of two words; the queue then fills.
        mem_push(26'h0, 32'h00221820);
        tick();
        check_head("t2_w0");
        chk("t2_funct20", 32'(Funct), 32'h20);
        check_mem("t2_next", 1'b1, 26'h1);
        mem_push(26'h1, 32'h00421822);
        tick();
        MEM_READY = 1'b0;
        check_mem("t3_full", 1'b0, 26'h0);
        check_head("t3_head");
        repeat (2) tick();
        check_mem("t3_stay", 1'b0, 26'h0);

        // One NEXT frees a slot: second word shown, then a single fetch at 2.
        NEXT = 1'b1;
        void'(sb.pop_front());
        tick();
        NEXT = 1'b0;
        check_head("t2_w1");
        chk("t2_funct22", 32'(Funct), 32'h22);
        chk("t2_rd3", 32'(ADDR_W), 32'd3);
        check_mem("t3_wait", 1'b0, 26'h0);
        tick();
        check_mem("t3_refetch", 1'b1, 26'h2);

        // NEXT and MEM_READY together with one entry queued: count stays 1.
        NEXT = 1'b1;
        void'(sb.pop_front());
        mem_push(26'h2, 32'h014B4824);
        tick();
        NEXT = 1'b0;
        check_head("t5_bypass");
        check_mem("t5_cont", 1'b1, 26'h3);
        mem_push(26'h3, 32'hFC000000);
        tick();
        MEM_READY = 1'b0;
        check_mem("t5_count1", 1'b0, 26'h0);
        NEXT = 1'b1;
        void'(sb.pop_front());
        tick();
        check_head("t5_nopword");
        void'(sb.pop_front());
        tick();
        NEXT = 1'b0;
        check_nop("t4_empty");
        check_mem("t4_fetch4", 1'b1, 26'h4);
        mem_push(26'h4, 32'h0128502A);
        tick();
        MEM_READY = 1'b0;
        check_head("t4_w4");
        check_mem("t4_wait5", 1'b1, 26'h5);
        tick();

        // Redirect while waiting at 5: drain, discard the late word, refetch at 0x40.
        PC_LOAD = 1'b1;
        PC_IN   = 26'h40;
        sb.delete();
        tick();
        PC_LOAD = 1'b0;
        check_mem("t4_drop", 1'b0, 26'h0);
        check_nop("t4_flush");
        repeat (2) tick();
        check_mem("t4_drain", 1'b0, 26'h0);
        MEM_DATA  = 32'hDEADBEEF;
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        check_nop("t4_discard");
        check_mem("t4_req40", 1'b1, 26'h40);
        tick();
        check_nop("t4_still");
        mem_push(26'h40, 32'h3C01ABCD);
        tick();
        MEM_READY = 1'b0;
        check_head("t4_w40");
        check_mem("t4_next41", 1'b1, 26'h41);

        // NEXT, MEM_READY and PC_LOAD in one cycle.
        NEXT      = 1'b1;
        PC_LOAD   = 1'b1;
        PC_IN     = 26'h80;
        MEM_DATA  = 32'h11111111;
        MEM_READY = 1'b1;
        sb.delete();
        tick();
        NEXT      = 1'b0;
        PC_LOAD   = 1'b0;
        MEM_READY = 1'b0;
        check_nop("t5_all");
        check_mem("t5_req80", 1'b1, 26'h80);
        mem_push(26'h80, 32'h000A5140);
        tick();
        MEM_READY = 1'b0;
        check_head("t5_w80");
        tick();

        // Asynchronous reset mid-wait, away from any clock edge.
        #2 RST = 1'b0;
        #1 check_reset("t6_async");
        sb.delete();
        tick();
        MEM_DATA  = 32'h00221820;
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        check_reset("t6_late");
        RST = 1'b1;
        tick();
        check_nop("t6_rel");
        check_mem("t6_req0", 1'b1, 26'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
